// File: rtl/llc_set_dispatch_if.sv
// Request-in, request-out and retire handshakes of the LLC set dispatcher.
// Pure signal bundle, no latency of its own.
// Valid/ready on both request channels; retire is fire-and-forget.
interface llc_set_dispatch_if #(
    parameter int LLC_SET_BITS = 8
);
    logic                    req_in_valid;
    logic [LLC_SET_BITS-1:0] req_in_set;
    logic                    req_in_ready;

    logic                    req_out_valid;
    logic                    req_out_ready;
    logic [LLC_SET_BITS-1:0] req_out_set;
    logic [2:0]              req_out_ptr;

    logic                    retire_valid;
    logic [2:0]              retire_ptr;

    // Environment side: produces requests/retires, consumes issued requests.
    modport master (
        output req_in_valid, req_in_set,
        input  req_in_ready,
        input  req_out_valid, req_out_set, req_out_ptr,
        output req_out_ready,
        output retire_valid, retire_ptr
    );

    // Dispatcher side.
    modport slave (
        input  req_in_valid, req_in_set,
        output req_in_ready,
        output req_out_valid, req_out_set, req_out_ptr,
        input  req_out_ready,
        input  retire_valid, retire_ptr
    );
endinterface

// File: rtl/llc_set_dispatch.sv
// Serialises LLC requests so no two in-flight transactions share a set or a table slot.
// Latency: accept (IDLE) -> lookup (CHECK) -> offer (ISSUE), so 2 cycles from acceptance to req_out_valid.
// Backpressure: req_in_ready only in IDLE; a set conflict or busy slot parks the request in STALL until a retire.
module llc_set_dispatch #(
    parameter int TABLE_SIZE   = 5,   // at most 7 so occupancy fits in 3 bits
    parameter int LLC_SET_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    llc_set_dispatch_if.slave       bus,
    output logic [LLC_SET_BITS-1:0] set_next,
    output logic                    check_set_table,
    output logic                    add_set_to_table,
    input  logic                    is_set_in_table,
    input  logic [2:0]              set_table_pointer,
    output logic                    remove_set_from_table,
    output logic [2:0]              table_pointer_to_remove,
    output logic [2:0]              occupancy,
    output logic                    stall,
    output logic                    retire_err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    localparam logic [3:0] TS4 = 4'(TABLE_SIZE);

    logic [1:0]              state_q, state_d;
    logic [TABLE_SIZE-1:0]   busy_q, busy_d;
    logic [LLC_SET_BITS-1:0] hold_set_q, hold_set_d;
    logic [2:0]              hold_ptr_q, hold_ptr_d;
    logic                    err_q, err_d;
    logic [2:0]              occ_q, occ_d;

    logic [7:0] busy_pad;
    logic [7:0] busy_pad_nxt;
    logic       retire_ok;
    logic       conflict;
    logic       add;

    function automatic logic [2:0] popcnt(input logic [TABLE_SIZE-1:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Busy vector widened to the full 3-bit pointer space; slots past the table read busy.
    always_comb begin
        busy_pad                 = 8'hFF;
        busy_pad[TABLE_SIZE-1:0] = busy_q;
    end

    // Retire qualification, conflict detection and the add strobe.
    always_comb begin
        retire_ok = !rst && bus.retire_valid && ({1'b0, bus.retire_ptr} < TS4)
                    && busy_pad[bus.retire_ptr];
        conflict  = is_set_in_table || busy_pad[set_table_pointer];
        add       = !rst && (state_q == ST_CHECK) && !conflict;
    end

    // Next-state for the FSM, the slot bookkeeping and the sticky error.
    always_comb begin
        state_d      = state_q;
        hold_set_d   = hold_set_q;
        hold_ptr_d   = hold_ptr_q;
        err_d        = err_q || (bus.retire_valid && !retire_ok);
        busy_pad_nxt = busy_pad;
        if (retire_ok) begin
            busy_pad_nxt[bus.retire_ptr] = 1'b0;
        end
        // add and retire never hit the same slot: one needs it free, the other busy
        if (add) begin
            busy_pad_nxt[set_table_pointer] = 1'b1;
        end
        busy_d = busy_pad_nxt[TABLE_SIZE-1:0];
        occ_d  = popcnt(busy_d);

        case (state_q)
            ST_IDLE: begin
                if (bus.req_in_valid) begin
                    hold_set_d = bus.req_in_set;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!conflict) begin
                    hold_ptr_d = set_table_pointer;
                    state_d    = ST_ISSUE;
                end else if (retire_ok) begin
                    // a retire landing on the lookup cycle re-runs the lookup
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (retire_ok) begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                if (bus.req_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= '0;
            hold_set_q <= '0;
            hold_ptr_q <= 3'd0;
            err_q      <= 1'b0;
            occ_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            hold_set_q <= hold_set_d;
            hold_ptr_q <= hold_ptr_d;
            err_q      <= err_d;
            occ_q      <= occ_d;
        end
    end

    // Output decode; everything but req_in_ready is held low while rst is high.
    always_comb begin
        bus.req_in_ready        = rst || (state_q == ST_IDLE);
        set_next                = (!rst && (state_q == ST_CHECK || state_q == ST_STALL))
                                  ? hold_set_q : '0;
        check_set_table         = !rst && (state_q == ST_CHECK);
        add_set_to_table        = add;
        remove_set_from_table   = retire_ok;
        table_pointer_to_remove = retire_ok ? bus.retire_ptr : 3'd0;
        stall                   = !rst && (state_q == ST_STALL);
        bus.req_out_valid       = !rst && (state_q == ST_ISSUE);
        bus.req_out_set         = bus.req_out_valid ? hold_set_q : '0;
        bus.req_out_ptr         = bus.req_out_valid ? hold_ptr_q : 3'd0;
        occupancy               = rst ? 3'd0 : occ_q;
        retire_err              = !rst && err_q;
    end
endmodule

// File: tb/tb_llc_set_dispatch.sv
// Self-checking bench for llc_set_dispatch: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level model of the dispatcher plus its set table.
module tb_llc_set_dispatch;
    localparam int TS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       is_set_in_table;
    logic [2:0] set_table_pointer;
    logic [7:0] set_next;
    logic       check_set_table, add_set_to_table, remove_set_from_table;
    logic [2:0] table_pointer_to_remove, occupancy;
    logic       stall, retire_err;

    llc_set_dispatch_if #(.LLC_SET_BITS(8)) bus ();

    llc_set_dispatch #(.TABLE_SIZE(TS), .LLC_SET_BITS(8)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus                     (bus),
        .set_next                (set_next),
        .check_set_table         (check_set_table),
        .add_set_to_table        (add_set_to_table),
        .is_set_in_table         (is_set_in_table),
        .set_table_pointer       (set_table_pointer),
        .remove_set_from_table   (remove_set_from_table),
        .table_pointer_to_remove (table_pointer_to_remove),
        .occupancy               (occupancy),
        .stall                   (stall),
        .retire_err              (retire_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: what the dispatcher is doing with its one held request, and the table contents.
    typedef enum int {WAITING, LOOKING, BLOCKED, OFFERING} phase_t;
    phase_t     m_phase;
    bit         m_busy [0:7];
    logic [7:0] m_tset [0:7];
    logic [7:0] m_hold;
    logic [2:0] m_ptr;
    bit         m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_table(input logic [7:0] s);
        for (int i = 0; i < TS; i++) if (m_busy[i] && m_tset[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < TS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_phase = WAITING;
        for (int i = 0; i < 8; i++) begin
            m_busy[i] = 1'b0;
            m_tset[i] = 8'h00;
        end
        m_hold = 8'h00;
        m_ptr  = 3'd0;
        m_err  = 1'b0;
    endtask

    // One clock: drive inputs, compare all outputs with the model, then advance the model.
    task automatic cycle(input bit r, input bit iv, input logic [7:0] iset, input bit rv,
                         input logic [2:0] rp, input bit ordy, input logic [2:0] tp);
        bit looking, ok, slot_taken, e_add;
        @(negedge clk);
        looking                = !r && m_phase == LOOKING;
        rst                    = r;
        bus.req_in_valid       = iv;
        bus.req_in_set         = iset;
        bus.retire_valid       = rv;
        bus.retire_ptr         = rp;
        bus.req_out_ready      = ordy;
        set_table_pointer      = tp;
        is_set_in_table        = looking ? in_table(m_hold) : 1'($urandom_range(0, 1));
        #1;
        ok         = !r && rv && int'(rp) < TS && m_busy[rp];
        slot_taken = int'(tp) >= TS || m_busy[tp];
        e_add      = looking && !in_table(m_hold) && !slot_taken;

        chk("req_in_ready", 32'(bus.req_in_ready), 32'(r || m_phase == WAITING));
        chk("set_next", 32'(set_next),
            (!r && (m_phase == LOOKING || m_phase == BLOCKED)) ? 32'(m_hold) : 0);
        chk("check_set_table", 32'(check_set_table), 32'(looking));
        chk("add_set_to_table", 32'(add_set_to_table), 32'(e_add));
        chk("remove_set_from_table", 32'(remove_set_from_table), 32'(ok));
        chk("table_pointer_to_remove", 32'(table_pointer_to_remove), ok ? 32'(rp) : 0);
        chk("stall", 32'(stall), 32'(!r && m_phase == BLOCKED));
        chk("req_out_valid", 32'(bus.req_out_valid), 32'(!r && m_phase == OFFERING));
        chk("req_out_set", 32'(bus.req_out_set), (!r && m_phase == OFFERING) ? 32'(m_hold) : 0);
        chk("req_out_ptr", 32'(bus.req_out_ptr), (!r && m_phase == OFFERING) ? 32'(m_ptr) : 0);
        chk("occupancy", 32'(occupancy), r ? 0 : 32'(busy_count()));
        chk("retire_err", 32'(retire_err), 32'(!r && m_err));

        if (r) begin
            model_reset();
        end else begin
            if (ok) m_busy[rp] = 1'b0;
            if (rv && !ok) m_err = 1'b1;
            case (m_phase)
                WAITING:  if (iv) begin m_hold = iset; m_phase = LOOKING; end
                LOOKING: begin
                    if (e_add) begin
                        m_busy[tp] = 1'b1;
                        m_tset[tp] = m_hold;
                        m_ptr      = tp;
                        m_phase    = OFFERING;
                    end else begin
                        m_phase = ok ? LOOKING : BLOCKED;
                    end
                end
                BLOCKED:  if (ok) m_phase = LOOKING;
                OFFERING: if (ordy) m_phase = WAITING;
                default:  m_phase = WAITING;
            endcase
        end
    endtask

    task automatic idle_cyc(input logic [2:0] tp);
        cycle(0, 0, 8'h00, 0, 3'd0, 0, tp);
    endtask

    // Full request walk: accept, lookup at slot tp, issue with immediate ready.
    task automatic push(input logic [7:0] s, input logic [2:0] tp);
        cycle(0, 1, s, 0, 3'd0, 0, tp);
        cycle(0, 0, 8'h00, 0, 3'd0, 0, tp);
        cycle(0, 0, 8'h00, 0, 3'd0, 1, tp);
    endtask

    initial begin
        logic [2:0] tp, rp;
        int nfree;
        logic [2:0] frees [$];
        model_reset();
        rst = 1'b1;
        bus.req_in_valid = 0; bus.req_in_set = 0; bus.retire_valid = 0;
        bus.retire_ptr = 0; bus.req_out_ready = 0;
        is_set_in_table = 0; set_table_pointer = 0;

        // Reset state
        cycle(1, 0, 8'h00, 0, 3'd0, 0, 3'd0);
        cycle(1, 1, 8'h55, 1, 3'd1, 1, 3'd0);
        idle_cyc(3'd0);
        chk("pin reset ready", 32'(bus.req_in_ready), 1);
        chk("pin reset occupancy", 32'(occupancy), 0);

        // Set 0x12, slot 0: add pulse in lookup, offer two cycles after acceptance
        cycle(0, 1, 8'h12, 0, 3'd0, 0, 3'd0);
        cycle(0, 0, 8'h00, 0, 3'd0, 0, 3'd0);
        chk("pin add pulse", 32'(add_set_to_table), 1);
        cycle(0, 0, 8'h00, 0, 3'd0, 1, 3'd1);
        chk("pin out set", 32'(bus.req_out_set), 32'h12);
        chk("pin out ptr", 32'(bus.req_out_ptr), 0);
        chk("pin occupancy 1", 32'(occupancy), 1);

        // Same set again: table hit stalls until slot 0 retires
        cycle(0, 1, 8'h12, 0, 3'd0, 0, 3'd1);
        cycle(0, 0, 8'h00, 0, 3'd0, 0, 3'd1);
        chk("pin no add on hit", 32'(add_set_to_table), 0);
        idle_cyc(3'd1);
        chk("pin stall", 32'(stall), 1);
        cycle(0, 0, 8'h00, 1, 3'd0, 0, 3'd1);
        chk("pin remove", 32'(remove_set_from_table), 1);
        cycle(0, 0, 8'h00, 0, 3'd0, 0, 3'd1);
        chk("pin add after wakeup", 32'(add_set_to_table), 1);
        cycle(0, 0, 8'h00, 0, 3'd0, 1, 3'd1);
        cycle(0, 0, 8'h00, 1, 3'd1, 0, 3'd0);

        // Fill every slot, then a sixth request blocks on the pointed-at slot
        for (int i = 0; i < TS; i++) push(8'h20 + 8'(i), 3'(i));
        cycle(0, 1, 8'h30, 0, 3'd0, 0, 3'd0);
        idle_cyc(3'd0);
        idle_cyc(3'd0);
        chk("pin full occupancy", 32'(occupancy), 5);
        chk("pin full stall", 32'(stall), 1);
        cycle(0, 0, 8'h00, 1, 3'd2, 0, 3'd0);
        idle_cyc(3'd0);
        idle_cyc(3'd0);
        chk("pin still stalled", 32'(stall), 1);
        cycle(0, 0, 8'h00, 1, 3'd0, 0, 3'd0);
        idle_cyc(3'd0);
        cycle(0, 0, 8'h00, 0, 3'd0, 1, 3'd0);

        // Retire on the conflicting lookup cycle keeps the lookup alive
        cycle(0, 1, 8'h21, 0, 3'd0, 0, 3'd2);
        cycle(0, 0, 8'h00, 1, 3'd3, 0, 3'd2);
        chk("pin lookup repeated", 32'(check_set_table), 1);
        idle_cyc(3'd2);
        cycle(0, 0, 8'h00, 1, 3'd1, 0, 3'd2);
        idle_cyc(3'd2);
        cycle(0, 0, 8'h00, 0, 3'd0, 1, 3'd2);

        // Illegal retires: idle slot 3, then out-of-range 6; error is sticky
        cycle(0, 0, 8'h00, 1, 3'd3, 0, 3'd0);
        chk("pin no remove idle", 32'(remove_set_from_table), 0);
        cycle(0, 0, 8'h00, 1, 3'd6, 0, 3'd0);
        chk("pin no remove oor", 32'(remove_set_from_table), 0);
        chk("pin err set", 32'(retire_err), 1);
        for (int i = 0; i < 3; i++) idle_cyc(3'd0);
        chk("pin err sticky", 32'(retire_err), 1);

        // Offer held without ready, then reset drops it
        cycle(0, 1, 8'h44, 1, 3'd0, 0, 3'd3);
        idle_cyc(3'd3);
        for (int i = 0; i < 4; i++) idle_cyc(3'd3);
        chk("pin held set", 32'(bus.req_out_set), 32'h44);
        cycle(1, 0, 8'h00, 0, 3'd0, 0, 3'd0);
        idle_cyc(3'd0);
        chk("pin post-reset ready", 32'(bus.req_in_ready), 1);
        chk("pin post-reset occ", 32'(occupancy), 0);
        chk("pin post-reset err", 32'(retire_err), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            frees.delete();
            for (int i = 0; i < TS; i++) if (!m_busy[i]) frees.push_back(3'(i));
            nfree = frees.size();
            if (nfree > 0 && $urandom_range(0, 9) < 7) tp = frees[$urandom_range(0, nfree - 1)];
            else tp = 3'($urandom_range(0, TS - 1));
            rp = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, TS - 1))
                                           : 3'($urandom_range(0, 7));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 7)), $urandom_range(0, 9) < 3, rp,
                  $urandom_range(0, 9) < 6, tp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
